// File: rtl/octree_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : octree_sram_responder
//  Description : Single-port SRAM responder for the octree master interface.
//                Word array with fixed-latency reads, a sequential clear
//                engine, sticky error flags and saturating access counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module octree_sram_responder #(
    parameter int DATA_BUS_WIDTH = 64,
    parameter int ADDR_BUS_WIDTH = 64,
    parameter int DEPTH          = 1024,
    parameter int LOG_DEPTH      = 10,
    parameter int READ_LATENCY   = 1,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_sram_CEN,
    input  logic [ADDR_BUS_WIDTH-1:0] mem_sram_A,
    input  logic [DATA_BUS_WIDTH-1:0] mem_sram_D,
    input  logic                      mem_sram_GWEN,
    output logic [DATA_BUS_WIDTH-1:0] mem_sram_Q,
    input  logic                      init_start,
    output logic                      init_busy,
    input  logic                      clr_stats,
    output logic [CNT_WIDTH-1:0]      rd_cnt,
    output logic [CNT_WIDTH-1:0]      wr_cnt,
    output logic [1:0]                err_flags
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                    r_state;
    logic [LOG_DEPTH-1:0]      r_ptr;
    logic [DATA_BUS_WIDTH-1:0] r_mem [DEPTH];

    logic [LOG_DEPTH-1:0]      w_idx;
    logic                      w_in_range;
    logic                      w_accept;
    logic                      w_rd_fire;
    logic                      w_wr_fire;
    logic                      w_busy_hit;
    logic [DATA_BUS_WIDTH-1:0] w_rd_data;
    logic                      w_out_vld;
    logic [DATA_BUS_WIDTH-1:0] w_out_dat;

    // The full address is compared so that any set upper bit counts as out of range.
    assign w_idx      = mem_sram_A[LOG_DEPTH-1:0];
    assign w_in_range = (mem_sram_A < ADDR_BUS_WIDTH'(DEPTH));
    assign w_accept   = (r_state == ST_IDLE) && !mem_sram_CEN;
    assign w_rd_fire  = w_accept && mem_sram_GWEN;
    assign w_wr_fire  = w_accept && !mem_sram_GWEN;
    assign w_busy_hit = (r_state == ST_CLEAR) && !mem_sram_CEN;
    assign w_rd_data  = w_in_range ? r_mem[w_idx] : '0;

    // Clear-engine FSM: walks the pointer over every word, busy is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            init_busy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (init_start) begin
                        r_state   <= ST_CLEAR;
                        r_ptr     <= '0;
                        init_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_ptr <= r_ptr + LOG_DEPTH'(1);
                    if (r_ptr == LOG_DEPTH'(DEPTH - 1)) begin
                        r_state   <= ST_IDLE;
                        init_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    init_busy <= 1'b0;
                end
            endcase
        end
    end

    // Array write port, shared between the clear engine and accepted writes (never both).
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_fire && w_in_range) begin
            r_mem[w_idx] <= mem_sram_D;
        end
    end

    // Latency 1 drives Q straight from the accept edge; longer latencies add stages.
    generate
        if (READ_LATENCY <= 1) begin : g_lat1
            assign w_out_vld = w_rd_fire;
            assign w_out_dat = w_rd_data;
        end else begin : g_pipe
            localparam int STAGES = READ_LATENCY - 1;
            logic [STAGES-1:0]         r_vld;
            logic [DATA_BUS_WIDTH-1:0] r_dat [STAGES];

            // Valid/data shift register between the accept edge and Q.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= '0;
                    for (int i = 0; i < STAGES; i++) r_dat[i] <= '0;
                end else begin
                    r_vld[0] <= w_rd_fire;
                    r_dat[0] <= w_rd_data;
                    for (int i = 1; i < STAGES; i++) begin
                        r_vld[i] <= r_vld[i-1];
                        r_dat[i] <= r_dat[i-1];
                    end
                end
            end

            assign w_out_vld = r_vld[STAGES-1];
            assign w_out_dat = r_dat[STAGES-1];
        end
    endgenerate

    // Q only moves when a valid read leaves the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_sram_Q <= '0;
        end else if (w_out_vld) begin
            mem_sram_Q <= w_out_dat;
        end
    end

    // Saturating counters and sticky flags; clr_stats overrides same-edge updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            err_flags <= '0;
        end else if (clr_stats) begin
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            err_flags <= '0;
        end else begin
            if (w_rd_fire && !(&rd_cnt)) rd_cnt <= rd_cnt + CNT_WIDTH'(1);
            if (w_wr_fire && !(&wr_cnt)) wr_cnt <= wr_cnt + CNT_WIDTH'(1);
            if (w_accept && !w_in_range) err_flags[0] <= 1'b1;
            if (w_busy_hit)              err_flags[1] <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_octree_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_octree_sram_responder
//  Description : Randomised scoreboard bench for octree_sram_responder. Two
//                instances (read latency 1 and 3) share one stimulus stream;
//                a narrow counter width makes saturation reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_octree_sram_responder;

    localparam int DW    = 64;
    localparam int AW    = 64;
    localparam int DEPTH = 1024;
    localparam int LD    = 10;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cen = 1'b1;
    logic [AW-1:0] a = '0;
    logic [DW-1:0] d = '0;
    logic          gwen = 1'b1;
    logic          init_start = 1'b0;
    logic          clr_stats = 1'b0;

    logic [DW-1:0] q1, q3;
    logic          busy1, busy3;
    logic [CW-1:0] rd1, rd3, wr1, wr3;
    logic [1:0]    err1, err3;

    always #5 clk = ~clk;

    octree_sram_responder #(.DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW), .DEPTH(DEPTH),
        .LOG_DEPTH(LD), .READ_LATENCY(1), .CNT_WIDTH(CW)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .mem_sram_CEN(cen), .mem_sram_A(a), .mem_sram_D(d),
        .mem_sram_GWEN(gwen), .mem_sram_Q(q1), .init_start(init_start), .init_busy(busy1),
        .clr_stats(clr_stats), .rd_cnt(rd1), .wr_cnt(wr1), .err_flags(err1));

    octree_sram_responder #(.DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW), .DEPTH(DEPTH),
        .LOG_DEPTH(LD), .READ_LATENCY(3), .CNT_WIDTH(CW)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .mem_sram_CEN(cen), .mem_sram_A(a), .mem_sram_D(d),
        .mem_sram_GWEN(gwen), .mem_sram_Q(q3), .init_start(init_start), .init_busy(busy3),
        .clr_stats(clr_stats), .rd_cnt(rd3), .wr_cnt(wr3), .err_flags(err3));

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb1[$];
    exp_t          sb3[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;

    // Reference state: what the memory should hold and what the status should read.
    logic [DW-1:0] mdl_mem [DEPTH];
    int            clear_left = 0;
    logic [CW-1:0] m_rd = '0;
    logic [CW-1:0] m_wr = '0;
    logic [1:0]    m_err = '0;
    logic [DW-1:0] exp_q1 = '0;
    logic [DW-1:0] exp_q3 = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_rd = '0; m_wr = '0; m_err = '0; clear_left = 0;
        sb1.delete(); sb3.delete();
        exp_q1 = '0; exp_q3 = '0;
    endtask

    // Apply one rising edge to the reference, from the inputs presented in that cycle.
    task automatic model_edge();
        bit            busy, acc, inr;
        logic [DW-1:0] rdv;
        exp_t          e;
        busy = (clear_left > 0);
        acc  = !busy && !cen;
        inr  = (a < 64'(DEPTH));
        rdv  = inr ? mdl_mem[a[LD-1:0]] : '0;
        if (busy) begin
            mdl_mem[DEPTH - clear_left] = '0;
            clear_left--;
        end else if (init_start) begin
            clear_left = DEPTH;
        end
        if (acc && !gwen && inr) mdl_mem[a[LD-1:0]] = d;
        if (acc && gwen) begin
            e.data = rdv; e.due = cyc;     sb1.push_back(e);
            e.due = cyc + 2;               sb3.push_back(e);
        end
        if (clr_stats) begin
            m_rd = '0; m_wr = '0; m_err = '0;
        end else begin
            if (acc && gwen && m_rd != '1) m_rd++;
            if (acc && !gwen && m_wr != '1) m_wr++;
            if (acc && !inr) m_err[0] = 1'b1;
            if (busy && !cen) m_err[1] = 1'b1;
        end
    endtask

    task automatic step(input logic c, input logic g, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic st, input logic cs);
        @(negedge clk);
        cen = c; gwen = g; a = addr; d = data; init_start = st; clr_stats = cs;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("busy_l1", 64'(busy1), 64'(clear_left > 0));
        check("busy_l3", 64'(busy3), 64'(clear_left > 0));
        check("rd_cnt_l1", 64'(rd1), 64'(m_rd));
        check("rd_cnt_l3", 64'(rd3), 64'(m_rd));
        check("wr_cnt_l1", 64'(wr1), 64'(m_wr));
        check("wr_cnt_l3", 64'(wr3), 64'(m_wr));
        check("err_l1", 64'(err1), 64'(m_err));
        check("err_l3", 64'(err3), 64'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        step(1'b0, 1'b0, addr, data, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] addr);
        step(1'b0, 1'b1, addr, '0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        cen = 1'b1; init_start = 1'b0; clr_stats = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_q_l1", q1, '0);
        check("rst_q_l3", q3, '0);
        check("rst_busy_l1", 64'(busy1), '0);
        check("rst_busy_l3", 64'(busy3), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops the expected word when its update edge arrives, otherwise expects Q to hold.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (sb1.size() > 0 && sb1[0].due == cyc) begin
                    e = sb1.pop_front(); exp_q1 = e.data;
                end
                if (sb3.size() > 0 && sb3[0].due == cyc) begin
                    e = sb3.pop_front(); exp_q3 = e.data;
                end
                check("q_lat1", q1, exp_q1);
                check("q_lat3", q3, exp_q3);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            n;
        logic [AW-1:0] ra;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_q", q1, '0);
        check("rst_rd_cnt", 64'(rd1), '0);
        check("rst_err", 64'(err3), '0);
        rst_n = 1'b1;

        // Initial clear gives the array defined contents.
        step(1'b1, 1'b1, '0, '0, 1'b1, 1'b0);
        n = 0;
        for (int k = 1; k <= 1100 && busy1; k++) begin
            n++;
            idle(1);
        end
        check("clear_len0", 64'(n), 64'(DEPTH));

        // Write then read the same word on the next cycle.
        step(1'b1, 1'b1, '0, '0, 1'b0, 1'b1);
        wr(64'd5, 64'hDEAD_BEEF_0123_4567);
        rd(64'd5);
        idle(4);

        // Out of range write and read.
        step(1'b1, 1'b1, '0, '0, 1'b0, 1'b1);
        wr(64'd1024, 64'hFF);
        rd(64'h1_0000_0005);
        idle(4);

        // Back-to-back reads, then Q must hold.
        for (int i = 0; i < 4; i++) wr(64'(i), 64'(10 + i));
        for (int i = 0; i < 4; i++) rd(64'(i));
        idle(6);

        // Randomised mixed traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       ra = {32'($urandom), 32'($urandom)};
                1:       ra = 64'(DEPTH) + 64'($urandom_range(0, 3));
                default: ra = 64'($urandom_range(0, 31));
            endcase
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), ra,
                 {32'($urandom), 32'($urandom)}, 1'b0, 1'($urandom_range(0, 49) == 0));
        end
        idle(4);

        // Counter saturation, then clear wins against a same-edge read.
        step(1'b1, 1'b1, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) rd(64'($urandom_range(0, 31)));
        check("rd_sat", 64'(rd1), 64'((1 << CW) - 1));
        step(1'b0, 1'b1, 64'd3, '0, 1'b0, 1'b1);
        check("rd_after_clr", 64'(rd3), '0);
        idle(4);

        // Fill with nonzero data, clear with an access at the 10th busy cycle.
        for (int i = 0; i < DEPTH; i++) wr(64'(i), {32'($urandom), 32'(i + 1)});
        step(1'b1, 1'b1, '0, '0, 1'b1, 1'b1);
        n = 0;
        for (int k = 1; k <= 1100 && busy1; k++) begin
            n++;
            step(k == 10 ? 1'b0 : 1'b1, 1'b1, 64'd7, '0, 1'b0, 1'b0);
        end
        check("clear_len", 64'(n), 64'(DEPTH));
        check("busy_err", 64'(err1), 64'b10);
        for (int i = 0; i < 40; i++) rd(64'($urandom_range(0, DEPTH - 1)));
        rd(64'(DEPTH - 1));
        idle(4);

        // Reset with a read in flight in the latency-3 instance.
        wr(64'd9, 64'h1234_5678_9ABC_DEF0);
        rd(64'd9);
        do_reset();
        idle(5);

        // Reset at cycle 500 of a clear; untouched words survive.
        for (int i = 600; i < 608; i++) wr(64'(i), 64'(i) * 64'h0101_0101);
        step(1'b1, 1'b1, '0, '0, 1'b1, 1'b0);
        idle(500);
        do_reset();
        idle(2);
        for (int i = 0; i < 4; i++) rd(64'(i));
        for (int i = 600; i < 608; i++) rd(64'(i));
        idle(6);

        check("sb1_drained", 64'(sb1.size()), '0);
        check("sb3_drained", 64'(sb3.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
